// File: rtl/pinmux_cfg_seq.sv
// Command-driven pinmux select-register sequencer: keeps a shadow of every packed select
// word and issues full-word writes. Optional response timeout: PINMUX_CFG_TIMEOUT_EN.
module pinmux_cfg_seq #(
    parameter int NPeriphIn     = 32,
    parameter int NPeriphOut    = 32,
    parameter int NMioPads      = 32,
    parameter int SelW          = 6,
    parameter int AddrW         = 12,
    parameter int TimeoutCycles = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // Command port: a command transfers on a cycle where cmd_valid_i and cmd_ready_o are
    // both high; ready is high only in IDLE and the command fields are sampled that cycle.
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [4:0]       cmd_idx_i,
    input  logic [SelW-1:0]  cmd_sel_i,
    output logic             done_o,
    output logic [2:0]       err_o,
    output logic             locked_o,
    output logic             wr_req_o,
    output logic [AddrW-1:0] wr_addr_o,
    output logic [31:0]      wr_data_o,
    input  logic             wr_gnt_i,
    input  logic             wr_rsp_i,
    input  logic             wr_rsp_err_i
);

    localparam int FieldsPerReg = 5;
    localparam int NRegIn       = (NPeriphIn + FieldsPerReg - 1) / FieldsPerReg;
    localparam int NRegOut      = (NMioPads + FieldsPerReg - 1) / FieldsPerReg;
    localparam int NRegMax      = (NRegIn > NRegOut) ? NRegIn : NRegOut;
    localparam int RegW         = (NRegMax > 1) ? $clog2(NRegMax) : 1;

    localparam logic [31:0] FieldMask = 32'((64'd1 << SelW) - 64'd1);
    localparam logic [31:0] WordMask  = 32'((64'd1 << (FieldsPerReg * SelW)) - 64'd1);

    localparam logic [AddrW-1:0] AddrRegen  = '0;
    localparam logic [AddrW-1:0] AddrInsel  = AddrW'(32'h04);
    localparam logic [AddrW-1:0] AddrOutsel = AddrW'(32'h20);

    localparam logic [2:0] ErrOk      = 3'd0;
    localparam logic [2:0] ErrCmd     = 3'd1;
    localparam logic [2:0] ErrLocked  = 3'd2;
    localparam logic [2:0] ErrBus     = 3'd3;
    localparam logic [2:0] ErrTimeout = 3'd4;

    typedef enum logic [1:0] {
        OP_INSEL  = 2'd0,
        OP_OUTSEL = 2'd1,
        OP_LOCK   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [RegW-1:0]   reg_q, reg_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        err_q, err_d;
    logic              locked_q, locked_d;
    logic [31:0]       shadow_in_q [NRegIn];
    logic [31:0]       shadow_in_d [NRegIn];
    logic [31:0]       shadow_out_q [NRegOut];
    logic [31:0]       shadow_out_d [NRegOut];

    logic              cmd_accept;
    op_e               cmd_op;
    logic [RegW-1:0]   cmd_reg;
    logic [2:0]        cmd_pos;
    logic              cmd_bad;
    logic [31:0]       cmd_base;
    logic [31:0]       cmd_data;
    logic [AddrW-1:0]  cmd_addr;
    logic [31:0]       idx_ext;
    logic [31:0]       sel_ext;
    int                cmd_shift;
    logic              timeout_hit;

    assign cmd_ready_o = rst_ni && (state_q == ST_IDLE);
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign cmd_op      = op_e'(cmd_op_i);
    assign cmd_reg     = RegW'(cmd_idx_i / 5'd5);
    assign cmd_pos     = 3'(cmd_idx_i % 5'd5);
    assign idx_ext     = 32'(cmd_idx_i);
    assign sel_ext     = 32'(cmd_sel_i);

    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_op)
            OP_INSEL:  cmd_bad = (idx_ext >= $unsigned(NPeriphIn)) ||
                                 (sel_ext > $unsigned(NMioPads + 1));
            OP_OUTSEL: cmd_bad = (idx_ext >= $unsigned(NMioPads)) ||
                                 (sel_ext > $unsigned(NPeriphOut + 2));
            OP_LOCK:   cmd_bad = 1'b0;
            default:   cmd_bad = 1'b1;
        endcase
    end

    // New register word: current shadow with one field replaced; unused top bits stay zero.
    always_comb begin
        cmd_base  = '0;
        cmd_addr  = AddrRegen;
        cmd_shift = int'(cmd_pos) * SelW;
        case (cmd_op)
            OP_INSEL: begin
                cmd_base = shadow_in_q[cmd_reg];
                cmd_addr = AddrInsel + AddrW'({cmd_reg, 2'b00});
            end
            OP_OUTSEL: begin
                cmd_base = shadow_out_q[cmd_reg];
                cmd_addr = AddrOutsel + AddrW'({cmd_reg, 2'b00});
            end
            default: begin
                cmd_base = '0;
                cmd_addr = AddrRegen;
            end
        endcase
        cmd_data = ((cmd_base & ~(FieldMask << cmd_shift)) | (sel_ext << cmd_shift)) & WordMask;
        if (cmd_op == OP_LOCK) begin
            cmd_data = '0;
        end
    end

`ifdef PINMUX_CFG_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter is zero in the first WAIT_RSP cycle and counts every cycle spent there.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT_RSP) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT_RSP) && (cnt_d == CntW'(TimeoutCycles));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the timeout the parameter only documents the interface; never true.
    assign timeout_hit = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        reg_d        = reg_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        locked_d     = locked_q;
        shadow_in_d  = shadow_in_q;
        shadow_out_d = shadow_out_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (locked_q) begin
                        err_d   = ErrLocked;
                        state_d = ST_DONE;
                    end else if (cmd_bad) begin
                        err_d   = ErrCmd;
                        state_d = ST_DONE;
                    end else begin
                        op_d    = cmd_op;
                        reg_d   = cmd_reg;
                        addr_d  = cmd_addr;
                        data_d  = cmd_data;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (wr_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (wr_rsp_i) begin
                    state_d = ST_DONE;
                    if (wr_rsp_err_i) begin
                        err_d = ErrBus;
                    end else begin
                        err_d = ErrOk;
                        case (op_q)
                            OP_INSEL:  shadow_in_d[reg_q]  = data_q;
                            OP_OUTSEL: shadow_out_d[reg_q] = data_q;
                            OP_LOCK:   locked_d            = 1'b1;
                            default:   locked_d            = locked_q;
                        endcase
                    end
                end else if (timeout_hit) begin
                    err_d   = ErrTimeout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_INSEL;
            reg_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            for (int i = 0; i < NRegIn; i++) begin
                shadow_in_q[i] <= '0;
            end
            for (int i = 0; i < NRegOut; i++) begin
                shadow_out_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            reg_q        <= reg_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            shadow_in_q  <= shadow_in_d;
            shadow_out_q <= shadow_out_d;
        end
    end

    assign done_o    = (state_q == ST_DONE);
    assign err_o     = err_q;
    assign locked_o  = locked_q;
    assign wr_req_o  = (state_q == ST_ISSUE);
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;

endmodule

// File: tb/tb_pinmux_cfg_seq.sv
// Bench for pinmux_cfg_seq: directed and random commands checked against a field-level
// model of the pinmux select registers. Honours PINMUX_CFG_TIMEOUT_EN like the design.
module tb_pinmux_cfg_seq;

    localparam int SelW          = 6;
    localparam int AddrW         = 12;
    localparam int TimeoutCycles = 255;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i = '0;
    logic [4:0]       cmd_idx_i = '0;
    logic [SelW-1:0]  cmd_sel_i = '0;
    logic             done_o;
    logic [2:0]       err_o;
    logic             locked_o;
    logic             wr_req_o;
    logic [AddrW-1:0] wr_addr_o;
    logic [31:0]      wr_data_o;
    logic             wr_gnt_i = 1'b0;
    logic             wr_rsp_i = 1'b0;
    logic             wr_rsp_err_i = 1'b0;

    pinmux_cfg_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_idx_i    (cmd_idx_i),
        .cmd_sel_i    (cmd_sel_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .locked_o     (locked_o),
        .wr_req_o     (wr_req_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_gnt_i     (wr_gnt_i),
        .wr_rsp_i     (wr_rsp_i),
        .wr_rsp_err_i (wr_rsp_err_i)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state: counters, expected bus writes, field-level model
    int n_tests = 0;
    int n_fail  = 0;
    logic [AddrW+31:0] exp_q[$];
    int m_in  [35];
    int m_out [35];
    bit m_locked;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 35; i++) begin
            m_in[i]  = 0;
            m_out[i] = 0;
        end
        m_locked = 1'b0;
    endtask

    function automatic int exp_err(input int op, input int idx, input int sel);
        if (m_locked) return 2;
        if (op == 0) return (idx >= 32 || sel > 33) ? 1 : 0;
        if (op == 1) return (idx >= 32 || sel > 34) ? 1 : 0;
        if (op == 2) return 0;
        return 1;
    endfunction

    function automatic int exp_addr(input int op, input int idx);
        if (op == 0) return 4 + 4 * (idx / 5);
        if (op == 1) return 32 + 4 * (idx / 5);
        return 0;
    endfunction

    // Register word = sum of its five fields, each weighted by 2^(6*position)
    function automatic logic [31:0] exp_data(input int op, input int idx, input int sel);
        logic [31:0] w;
        int base;
        int v;
        w = '0;
        if (op == 2) return w;
        base = 5 * (idx / 5);
        for (int p = 0; p < 5; p++) begin
            if (base + p == idx) v = sel;
            else v = (op == 0) ? m_in[base + p] : m_out[base + p];
            w = w + 32'(v) * (32'd1 << (6 * p));
        end
        return w;
    endfunction

    task automatic model_commit(input int op, input int idx, input int sel);
        if (op == 0) m_in[idx] = sel;
        else if (op == 1) m_out[idx] = sel;
        else if (op == 2) m_locked = 1'b1;
    endtask

    // Driver: called at a negedge while the DUT is in ISSUE; pops and checks the bus word
    task automatic grant_now(input string tag, input bit rsp_too);
        logic [AddrW+31:0] e;
        check({tag, ".q"}, 64'(exp_q.size() > 0), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, ".bus"}, 64'({wr_addr_o, wr_data_o}), 64'(e));
        wr_gnt_i = 1'b1;
        wr_rsp_i = rsp_too;
        @(negedge clk_i);
        wr_gnt_i = 1'b0;
        wr_rsp_i = 1'b0;
    endtask

    task automatic send(input int op, input int idx, input int sel);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'(op);
        cmd_idx_i   = 5'(idx);
        cmd_sel_i   = SelW'(sel);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // Full transaction; starts with the DUT idle, ends one cycle after done_o
    task automatic do_cmd(input string tag, input int op, input int idx, input int sel,
                          input int gnt_dly, input int rsp_dly, input bit rsp_err,
                          input bit rsp_with_gnt);
        int e;
        logic [31:0] a;
        logic [31:0] d;
        e = exp_err(op, idx, sel);
        a = 32'(exp_addr(op, idx));
        d = exp_data(op, idx, sel);
        check({tag, ".ready"}, 64'(cmd_ready_o), 64'd1);
        send(op, idx, sel);
        if (e != 0) begin
            check({tag, ".nobus"}, 64'(wr_req_o), 64'd0);
            check({tag, ".done"}, 64'(done_o), 64'd1);
            check({tag, ".err"}, 64'(err_o), 64'(e));
        end else begin
            exp_q.push_back({a[AddrW-1:0], d});
            for (int k = 0; k < gnt_dly; k++) begin
                check({tag, ".hold"}, 64'({wr_req_o, wr_addr_o, wr_data_o}),
                      64'({1'b1, a[AddrW-1:0], d}));
                @(negedge clk_i);
            end
            check({tag, ".req"}, 64'(wr_req_o), 64'd1);
            grant_now(tag, rsp_with_gnt);
            check({tag, ".reqoff"}, 64'(wr_req_o), 64'd0);
            for (int k = 0; k < rsp_dly; k++) begin
                check({tag, ".early"}, 64'(done_o), 64'd0);
                @(negedge clk_i);
            end
            wr_rsp_i     = 1'b1;
            wr_rsp_err_i = rsp_err;
            @(negedge clk_i);
            wr_rsp_i     = 1'b0;
            wr_rsp_err_i = 1'b0;
            check({tag, ".done"}, 64'(done_o), 64'd1);
            check({tag, ".err"}, 64'(err_o), rsp_err ? 64'd3 : 64'd0);
            if (!rsp_err) model_commit(op, idx, sel);
        end
        @(negedge clk_i);
        check({tag, ".pulse"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        int n;
        bit saw_done;
        model_reset();

        // Reset values
        #1 rst_ni = 1'b0;
        #2;
        check("rst.ready", 64'(cmd_ready_o), 64'd0);
        check("rst.outs", 64'({done_o, err_o, locked_o, wr_req_o, wr_addr_o, wr_data_o}), 64'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rel.ready", 64'(cmd_ready_o), 64'd1);

        // Minimum-latency write: done on the third cycle after accept
        do_cmd("insel7", 0, 7, 9, 0, 0, 1'b0, 1'b0);
        // Build 0x24 = 0x5, then update a neighbour field with a slow grant
        do_cmd("out5", 1, 5, 5, 0, 1, 1'b0, 1'b0);
        do_cmd("out6", 1, 6, 3, 4, 0, 1'b0, 1'b0);
        check("out6.word", 64'(exp_data(1, 6, 3)), 64'h0000_00C5);

        // Rejections and range boundaries
        do_cmd("rej_sel", 0, 31, 34, 0, 0, 1'b0, 1'b0);
        do_cmd("rej_op3", 3, 2, 1, 0, 0, 1'b0, 1'b0);
        do_cmd("rej_osel", 1, 9, 35, 0, 0, 1'b0, 1'b0);
        do_cmd("ok_osel34", 1, 31, 34, 1, 1, 1'b0, 1'b0);
        do_cmd("ok_isel33", 0, 30, 33, 0, 2, 1'b0, 1'b0);

        // Bus error keeps the shadow; neighbour write carries the old word
        do_cmd("buserr", 0, 10, 4, 0, 0, 1'b1, 1'b0);
        do_cmd("after_err", 0, 11, 2, 0, 0, 1'b0, 1'b0);

        // Response in the grant cycle must not complete the command
        do_cmd("rsp_gnt", 0, 12, 1, 1, 2, 1'b0, 1'b1);

        // No response after grant
        send(0, 20, 3);
        exp_q.push_back({AddrW'(exp_addr(0, 20)), exp_data(0, 20, 3)});
        grant_now("norsp", 1'b0);
`ifdef PINMUX_CFG_TIMEOUT_EN
        n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("to.cycles", 64'(n), 64'(TimeoutCycles));
        check("to.done", 64'(done_o), 64'd1);
        check("to.err", 64'(err_o), 64'd4);
        @(negedge clk_i);
`else
        saw_done = 1'b0;
        repeat (300) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        check("wait.nodone", 64'(saw_done), 64'd0);
        wr_rsp_i = 1'b1;
        @(negedge clk_i);
        wr_rsp_i = 1'b0;
        check("wait.done", 64'(done_o), 64'd1);
        check("wait.err", 64'(err_o), 64'd0);
        model_commit(0, 20, 3);
        @(negedge clk_i);
`endif
        // Stray response while idle is ignored
        wr_rsp_i = 1'b1;
        @(negedge clk_i);
        wr_rsp_i = 1'b0;
        check("late.done", 64'(done_o), 64'd0);
        check("late.ready", 64'(cmd_ready_o), 64'd1);
        do_cmd("after_late", 0, 21, 1, 0, 0, 1'b0, 1'b0);

        // Randomized traffic (no LOCK)
        for (int i = 0; i < 40; i++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 1));
            do_cmd("rnd", op, int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        // Lock, then everything is refused with err 2
        do_cmd("lock", 2, 0, 0, 1, 1, 1'b0, 1'b0);
        check("lock.flag", 64'(locked_o), 64'd1);
        do_cmd("lkd_out", 1, 0, 5, 0, 0, 1'b0, 1'b0);
        do_cmd("lkd_op3", 3, 0, 0, 0, 0, 1'b0, 1'b0);
        do_cmd("lkd_lock", 2, 0, 0, 0, 0, 1'b0, 1'b0);
        check("lkd.flag", 64'(locked_o), 64'd1);

        // Reset clears lock and shadow
        rst_ni = 1'b0;
        #1;
        check("rst2.lock", 64'(locked_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        #1;
        do_cmd("post_rst", 0, 11, 7, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a write aborts it without done_o
        send(1, 14, 2);
        check("abort.req", 64'(wr_req_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("abort.outs", 64'({cmd_ready_o, wr_req_o, done_o, locked_o}), 64'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        check("abort.nodone", 64'(saw_done), 64'd0);
        rst_ni = 1'b1;
        model_reset();
        #1;
        do_cmd("after_abort", 1, 13, 6, 0, 1, 1'b0, 1'b0);

        // Final report
        check("bus.drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
